iomem_sw_debounce: RTL and testbench

- Memory-mapped switch-input peripheral on the PicoSoC iomem bus, downstream of the SoC iomem master, alongside the GPIO/LED register.
- Synchronises and debounces the board switches and latches rising/falling edge events.
- Raises a level interrupt for enabled events.
- Answers iomem transactions in its address window with the same one-cycle ready pulse the GPIO register uses.

---
 rtl/iomem_sw_debounce.sv | 116 +++++++++++
 tb/tb_iomem_sw_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_sw_debounce.sv
// Switch-input peripheral on the PicoSoC iomem bus: synchronises and debounces
// the board switches, latches edge events and raises a level interrupt.
module iomem_sw_debounce #(
    parameter int         NUM_SW          = 4,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [7:0] BASE_ADDR       = 8'h04
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_in,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic              irq
);

    localparam logic [31:0] SW_MASK  = 32'((64'd1 << NUM_SW) - 64'd1);
    localparam logic [31:0] EVT_MASK = SW_MASK | (SW_MASK << 16);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] sw_meta;
    logic [NUM_SW-1:0] sw_sync;
    logic [NUM_SW-1:0] stable;
    logic [NUM_SW-1:0] stable_nxt;
    logic [15:0]       cnt [NUM_SW];

    logic [31:0] event_q;
    logic [31:0] irq_en;
    logic [31:0] evt_set;
    logic [31:0] evt_clr;
    logic [31:0] byte_mask;
    logic [31:0] wr_val;
    logic [31:0] rd_val;
    logic [1:0]  sel;
    logic        accept;
    logic        is_write;
    logic        unused_addr_bits;

    // Handshake: a request in our window is accepted on the edge where
    // iomem_valid=1 and iomem_ready=0; iomem_ready then pulses high for one
    // cycle carrying rdata, so a held request is acknowledged every other cycle.
    assign accept    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign is_write  = |iomem_wstrb;
    assign sel       = iomem_addr[3:2];
    assign byte_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wr_val    = iomem_wdata & byte_mask & EVT_MASK;
    assign evt_clr   = (accept && is_write && sel == 2'd1) ? wr_val : 32'd0;
    assign unused_addr_bits = ^{iomem_addr[23:4], iomem_addr[1:0]};

    // Next stable level and the edge events it produces on this clock.
    always_comb begin
        stable_nxt = stable;
        evt_set    = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw_sync[i] != stable[i] && cnt[i] == CNT_LAST)
                stable_nxt[i] = sw_sync[i];
            evt_set[i]      = stable_nxt[i] & ~stable[i];
            evt_set[16 + i] = stable[i] & ~stable_nxt[i];
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            2'd0:    rd_val = 32'(stable);
            2'd1:    rd_val = event_q;
            2'd2:    rd_val = irq_en;
            default: rd_val = 32'(sw_sync);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
            stable  <= '0;
            for (int i = 0; i < NUM_SW; i++)
                cnt[i] <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            stable  <= stable_nxt;
            for (int i = 0; i < NUM_SW; i++) begin
                if (sw_sync[i] == stable[i] || cnt[i] == CNT_LAST)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    // A new event on the same edge as its W1C survives: set is OR'd in last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_q     <= '0;
            irq_en      <= '0;
            irq         <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            event_q     <= (event_q & ~evt_clr) | evt_set;
            irq         <= |(event_q & irq_en);
            iomem_ready <= accept;
            if (accept) begin
                iomem_rdata <= rd_val;
                if (is_write && sel == 2'd2)
                    irq_en <= (irq_en & ~(byte_mask & EVT_MASK)) | wr_val;
            end
        end
    end

endmodule

// File: tb/tb_iomem_sw_debounce.sv
// Directed bench for iomem_sw_debounce with DEBOUNCE_CYCLES=8: a clean switch
// change reaches STATE on the 10th clock edge after it appears on sw_in.
module tb_iomem_sw_debounce;

    localparam logic [31:0] A_STATE  = 32'h0400_0000;
    localparam logic [31:0] A_EVENT  = 32'h0400_0004;
    localparam logic [31:0] A_IRQ_EN = 32'h0400_0008;
    localparam logic [31:0] A_RAW    = 32'h0400_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sw_in = 4'd0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;
    bit          last_ok;
    logic        irq_at_ready = 1'b0;

    iomem_sw_debounce #(
        .NUM_SW(4),
        .DEBOUNCE_CYCLES(8),
        .BASE_ADDR(8'h04)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_in(sw_in),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; returns right after a negedge.
    task automatic bus_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] r, output bit got);
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        iomem_valid = 1'b1;
        got = 1'b0;
        r   = '0;
        for (int n = 0; n < 4 && !got; n++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin
                got = 1'b1;
                r = iomem_rdata;
                irq_at_ready = irq;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
            chk("ready_pulse", 32'(iomem_ready), 32'd0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        @(negedge clk);
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_req(a, 4'd0, 32'd0, last_rd, last_ok);
        chk({tag, "_ack"}, 32'(last_ok), 32'd1);
        chk(tag, last_rd, exp);
    endtask

    task automatic wr_reg(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        bus_req(a, s, d, last_rd, last_ok);
        chk({tag, "_ack"}, 32'(last_ok), 32'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sw_in = 4'b0001;
        settle(3);
        rd_reg("raw_pre_reset", A_RAW, 32'h1);

        // Reset while sw[0] is mid-count
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(iomem_ready), 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Held request: acks on edges 9 and 11 after release
        repeat (8) @(posedge clk);
        @(negedge clk);
        iomem_addr  = A_STATE;
        iomem_wstrb = 4'd0;
        iomem_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_e9", 32'(iomem_ready), 32'd1);
        chk("state_e9", iomem_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("gap_e10", 32'(iomem_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ack_e11", 32'(iomem_ready), 32'd1);
        chk("state_e11", iomem_rdata, 32'h1);
        iomem_valid = 1'b0;
        @(negedge clk);
        rd_reg("event_after_reset", A_EVENT, 32'h0000_0001);
        wr_reg("event_clr0", A_EVENT, 4'hF, 32'hFFFF_FFFF);
        rd_reg("event_cleared0", A_EVENT, 32'h0);

        // Clean edge 0 -> 0101
        sw_in = 4'b0000;
        settle(12);
        wr_reg("event_clr1", A_EVENT, 4'hF, 32'hFFFF_FFFF);
        sw_in = 4'b0101;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rd_reg("state_edge10", A_STATE, 32'h0);
        rd_reg("state_edge12", A_STATE, 32'h5);
        rd_reg("event_clean", A_EVENT, 32'h0000_0005);
        chk("irq_clean", 32'(irq), 32'd0);

        // Bounce rejection on sw[2]
        sw_in = 4'b0001;
        settle(12);
        wr_reg("event_clr2", A_EVENT, 4'hF, 32'hFFFF_FFFF);
        sw_in[2] = 1'b1;
        settle(5);
        sw_in[2] = 1'b0;
        settle(1);
        sw_in[2] = 1'b1;
        settle(5);
        sw_in[2] = 1'b0;
        settle(12);
        rd_reg("state_bounce", A_STATE, 32'h1);
        rd_reg("event_bounce", A_EVENT, 32'h0);
        chk("irq_bounce", 32'(irq), 32'd0);

        // IRQ on fall of sw[0]
        wr_reg("irq_en_w", A_IRQ_EN, 4'hF, 32'h0001_0000);
        sw_in = 4'b0000;
        settle(12);
        rd_reg("event_fall", A_EVENT, 32'h0001_0000);
        chk("irq_fall", 32'(irq), 32'd1);
        wr_reg("event_w1c", A_EVENT, 4'hF, 32'h0001_0000);
        chk("irq_at_ready", 32'(irq_at_ready), 32'd1);
        chk("irq_after_w1c", 32'(irq), 32'd0);
        rd_reg("event_w1c_done", A_EVENT, 32'h0);

        // W1C on the same edge as a new fall event: set wins
        sw_in = 4'b0001;
        settle(12);
        wr_reg("event_clr3", A_EVENT, 4'hF, 32'hFFFF_FFFF);
        sw_in = 4'b0000;
        repeat (9) @(posedge clk);
        @(negedge clk);
        wr_reg("event_w1c_race", A_EVENT, 4'hF, 32'h0001_0000);
        rd_reg("event_set_wins", A_EVENT, 32'h0001_0000);
        chk("irq_set_wins", 32'(irq), 32'd1);
        wr_reg("event_clr4", A_EVENT, 4'hF, 32'hFFFF_FFFF);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Bus protocol
        sw_in = 4'b1010;
        settle(3);
        rd_reg("raw_c", A_RAW, 32'h0000_000A);
        rd_reg("raw_f", 32'h0400_000F, 32'h0000_000A);
        bus_req(32'h0300_0000, 4'd0, 32'd0, last_rd, last_ok);
        chk("foreign_rd_ack", 32'(last_ok), 32'd0);
        chk("rdata_hold", iomem_rdata, 32'h0000_000A);
        bus_req(32'h0300_0008, 4'hF, 32'hFFFF_FFFF, last_rd, last_ok);
        chk("foreign_wr_ack", 32'(last_ok), 32'd0);
        wr_reg("irq_en_lane2", A_IRQ_EN, 4'b0100, 32'hFFFF_FFFF);
        chk("irq_en_prewrite", last_rd, 32'h0001_0000);
        rd_reg("irq_en_lane2_rd", A_IRQ_EN, 32'h000F_0000);
        wr_reg("state_ro_w", A_STATE, 4'hF, 32'hFFFF_FFFF);
        settle(12);
        rd_reg("state_ro", A_STATE, 32'h0000_000A);
        rd_reg("event_rise_1010", A_EVENT, 32'h0000_000A);
        chk("irq_rise_masked", 32'(irq), 32'd0);
        wr_reg("irq_en_lane0", A_IRQ_EN, 4'b0001, 32'hFFFF_FFFF);
        settle(1);
        chk("irq_rise_enabled", 32'(irq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
